// File: rtl/sram_bank_sequencer_if.sv
// Host-side request/response bundle for the SRAM bank sequencer.
// The host (GPIO side) uses the master modport and the sequencer uses the slave modport.
interface sram_bank_sequencer_if #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ADDR_W = 10
);
  localparam int unsigned NumLanes = WORD_W / 8;
  localparam int unsigned SelW     = (NumLanes > 1) ? $clog2(NumLanes) : 1;

  logic [7:0]        byte_in;
  logic              byte_ld;
  logic [SelW-1:0]   byte_sel;
  logic [1:0]        bank_sel;
  logic [ADDR_W-1:0] word_sel;
  logic              wr_req;
  logic              rd_req;
  logic              busy;
  logic              rd_valid;
  logic [7:0]        byte_out;
  logic [WORD_W-1:0] rd_word;
  logic              wr_done;
  logic              sel_err;

  modport master (
    output byte_in, byte_ld, byte_sel, bank_sel, word_sel, wr_req, rd_req,
    input  busy, rd_valid, byte_out, rd_word, wr_done, sel_err
  );

  modport slave (
    input  byte_in, byte_ld, byte_sel, bank_sel, word_sel, wr_req, rd_req,
    output busy, rd_valid, byte_out, rd_word, wr_done, sel_err
  );
endinterface

// File: rtl/sram_bank_sequencer.sv
// Timed precharge/read/write sequencer for NUM_BANKS SRAM macros.
// Bytes from the host are staged into a word, committed or read back through a fixed
// PRE -> WRITE/READ -> DONE sequence driving per-bank PRE/ReadEn/WriteEn strobes.
module sram_bank_sequencer #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned PRE_CYC   = 2,
  parameter int unsigned RD_CYC    = 2,
  parameter int unsigned WR_CYC    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  sram_bank_sequencer_if.slave          host,
  output logic [ADDR_W-1:0]             bank_addr,
  output logic [WORD_W-1:0]             bank_din,
  output logic [NUM_BANKS-1:0]          bank_pre,
  output logic [NUM_BANKS-1:0]          bank_rd_en,
  output logic [NUM_BANKS-1:0]          bank_wr_en,
  input  logic [NUM_BANKS*WORD_W-1:0]   bank_dout
);

  localparam int unsigned MaxPr  = (PRE_CYC > RD_CYC) ? PRE_CYC : RD_CYC;
  localparam int unsigned MaxCyc = (MaxPr > WR_CYC) ? MaxPr : WR_CYC;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0] PreLoad = CntW'(PRE_CYC - 1);
  localparam logic [CntW-1:0] RdLoad  = CntW'(RD_CYC - 1);
  localparam logic [CntW-1:0] WrLoad  = CntW'(WR_CYC - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StPre   = 3'd1;
  localparam logic [2:0] StWrite = 3'd2;
  localparam logic [2:0] StRead  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              op_wr_q, op_wr_d;
  logic [1:0]        bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] stage_q, stage_d;
  logic [WORD_W-1:0] rd_word_q, rd_word_d;

  logic [WORD_W-1:0]    sel_dout;
  logic [NUM_BANKS-1:0] bank_oh;
  logic                 bank_ok;

  // An out-of-range latched bank decodes to no one-hot bit, so its sequence drives no strobes.
  assign bank_ok = (32'(bank_q) < NUM_BANKS);

  // Decode the latched bank to a one-hot strobe mask and pick its DataOut bus.
  always_comb begin
    bank_oh  = '0;
    sel_dout = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (bank_q == 2'(k)) begin
        bank_oh[k] = 1'b1;
        sel_dout   = bank_dout[k*WORD_W +: WORD_W];
      end
    end
  end

  // Next-state logic: request acceptance, byte staging, timed phase counting and read capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_wr_d   = op_wr_q;
    bank_d    = bank_q;
    addr_d    = addr_q;
    stage_d   = stage_q;
    rd_word_d = rd_word_q;
    unique case (state_q)
      StIdle: begin
        // The byte load lands on the same edge as a write accept, so the commit sees it.
        if (host.byte_ld) begin
          stage_d[8*host.byte_sel +: 8] = host.byte_in;
        end
        if (host.wr_req || host.rd_req) begin
          op_wr_d = host.wr_req;
          bank_d  = host.bank_sel;
          addr_d  = host.word_sel;
          cnt_d   = PreLoad;
          state_d = StPre;
        end
      end
      StPre: begin
        if (cnt_q == '0) begin
          state_d = op_wr_q ? StWrite : StRead;
          cnt_d   = op_wr_q ? WrLoad : RdLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWrite: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRead: begin
        if (cnt_q == '0) begin
          rd_word_d = bank_ok ? sel_dout : '0;
          state_d   = StDone;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset clears everything including in-flight data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_wr_q   <= 1'b0;
      bank_q    <= '0;
      addr_q    <= '0;
      stage_q   <= '0;
      rd_word_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_wr_q   <= op_wr_d;
      bank_q    <= bank_d;
      addr_q    <= addr_d;
      stage_q   <= stage_d;
      rd_word_q <= rd_word_d;
    end
  end

  // Strobes are decoded straight from the state register so an async reset drops them at once.
  assign bank_pre   = (state_q == StPre)   ? bank_oh : '0;
  assign bank_wr_en = (state_q == StWrite) ? bank_oh : '0;
  assign bank_rd_en = (state_q == StRead)  ? bank_oh : '0;

  assign bank_addr = addr_q;
  assign bank_din  = stage_q;

  assign host.busy     = (state_q == StPre) || (state_q == StWrite) || (state_q == StRead);
  assign host.rd_valid = (state_q == StDone) && !op_wr_q;
  assign host.wr_done  = (state_q == StDone) && op_wr_q;
  assign host.sel_err  = (state_q == StDone) && !bank_ok;
  assign host.rd_word  = rd_word_q;
  assign host.byte_out = rd_word_q[8*host.byte_sel +: 8];

endmodule
